clock_freq_meter: RTL
=====================

CLOCK_FREQ_METER -- requirements
Module: clock_freq_meter

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the period/high-time counters and outputs.
REQ-002 Parameter SYNC_STAGES, default 2, min 2, SHALL set the flip-flop depth of the input synchronizer.
REQ-003 i_clk  input  1  SHALL be the single measurement clock; all state SHALL update on its rising edge.
REQ-004 i_reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_enable  input  1  SHALL gate measurement; high = measure.
REQ-006 i_sig  input  1  SHALL be the asynchronous periodic signal under test, e.g. a divided clock.
REQ-007 o_period  output  CNT_W  SHALL be the last measured period in i_clk cycles.
REQ-008 o_high  output  CNT_W  SHALL be the last measured high time in i_clk cycles.
REQ-009 o_valid  output  1  SHALL be a one-cycle pulse marking an update of o_period/o_high.
REQ-010 o_timeout  output  1  SHALL be a sticky flag for no rising edge within 2^CNT_W-1 cycles.

Function
REQ-011 i_sig SHALL pass through SYNC_STAGES flops, then one edge-detect flop; rise/fall SHALL be decoded from the last two stages.
REQ-012 FSM SHALL have states WAIT_FIRST and MEASURE; reset and i_enable low SHALL force WAIT_FIRST.
REQ-013 In WAIT_FIRST, a detected rise SHALL clear both counters to 1 and enter MEASURE; no o_valid.
REQ-014 In MEASURE, the period counter SHALL increment every cycle; the high counter SHALL increment only while synchronized i_sig is high.
REQ-015 A detected fall in MEASURE SHALL freeze the high counter until the next rise.
REQ-016 A detected rise in MEASURE SHALL load o_period and o_high from the counters in that cycle, pulse o_valid the next cycle, reset the counters to 1, and clear o_timeout.
REQ-017 For i_sig with period P and high time H (in i_clk cycles), o_period SHALL equal P and o_high SHALL equal H, exact for synchronous i_sig.
REQ-018 o_valid latency SHALL be SYNC_STAGES+2 i_clk cycles after i_clk first samples i_sig high.
REQ-019 If the period counter reaches 2^CNT_W-1 without a rise, the block SHALL:
- set o_timeout
- load o_period=0 and o_high=0
- pulse o_valid
- return to WAIT_FIRST
REQ-020 Counters SHALL never wrap; the timeout rule governs saturation.
REQ-021 Deasserting i_enable SHALL hold o_period/o_high/o_timeout and suppress o_valid; re-enable SHALL restart from WAIT_FIRST.
REQ-022 A rise in the same cycle as timeout SHALL take precedence as a normal measurement.

Reset
REQ-023 On i_reset_n low, asynchronously:
- all outputs SHALL be 0
- synchronizer and edge flops SHALL be 0
- counters SHALL be 0
- FSM SHALL be WAIT_FIRST
REQ-024 Reset mid-measurement SHALL discard the partial count; the first rise after release SHALL NOT produce o_valid.

Configuration
REQ-025 With macro CLOCK_FREQ_METER_DUTY_EN defined, the high counter and o_high SHALL be as above.
REQ-026 Without CLOCK_FREQ_METER_DUTY_EN, the high counter SHALL be omitted and o_high SHALL be tied to 0; period, valid and timeout behaviour SHALL be unchanged.

Verification
REQ-027 i_sig from the team clock divider (100 MHz in, 10 MHz out), enable high -> every o_valid after the first shows o_period=10, o_high=5 (o_high=0 without the macro).
REQ-028 Synchronous i_sig with period 7, high 3 -> o_period=7, o_high=3; first o_valid exactly SYNC_STAGES+2 cycles after the second rise is sampled.
REQ-029 CNT_W=8, i_sig held low after one rise -> o_timeout=1 and o_valid with o_period=0 after 255 cycles; the next two rises -> normal period and o_timeout=0.
REQ-030 i_reset_n pulsed low mid-period -> outputs 0 immediately, no o_valid on the first post-reset rise, correct value on the second.
REQ-031 i_enable dropped for 50 cycles during toggling -> no o_valid, outputs held; after re-enable the first valid period is correct.

Source files
------------

// File: rtl/clock_freq_meter.sv
// Period / high-time meter for an asynchronous periodic signal, counted in i_clk cycles.
// Define CLOCK_FREQ_METER_DUTY_EN to build the high-time counter; without it o_high is tied to 0.
module clock_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_timeout
);

  // state      | meaning
  // WAIT_FIRST | no reference rise yet; counters idle, next rise starts a period
  // MEASURE    | counting since the last rise; next rise reports, saturation times out
  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   rise_q;

  state_t                 state_q;
  logic [CNT_W-1:0]       per_cnt_q;
  logic [CNT_W-1:0]       period_q;
  logic [CNT_W-1:0]       high_q;
  logic                   timeout_q;
  logic                   pend_q;
  logic                   valid_q;

  logic                   start_ev;
  logic                   meas_ev;
  logic                   tmo_ev;
  logic [CNT_W-1:0]       hi_val;

  // Edge strobes are registered, so edge_q is the signal level aligned with rise_q.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_sig};
      edge_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

  always_comb begin
    start_ev = i_enable && (state_q == WAIT_FIRST) && rise_q;
    meas_ev  = i_enable && (state_q == MEASURE) && rise_q;
    tmo_ev   = i_enable && (state_q == MEASURE) && !rise_q && (per_cnt_q == CNT_MAX);
  end

`ifdef CLOCK_FREQ_METER_DUTY_EN
  logic             fall_q;
  logic [CNT_W-1:0] hi_cnt_q;
  logic             hi_run_q;

  // High count never exceeds the period count, so it cannot wrap before a timeout.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fall_q   <= 1'b0;
      hi_cnt_q <= '0;
      hi_run_q <= 1'b0;
    end else begin
      fall_q <= ~sync_q[SYNC_STAGES-1] & edge_q;
      if (start_ev || meas_ev) begin
        hi_cnt_q <= CNT_ONE;
        hi_run_q <= 1'b1;
      end else if (i_enable && (state_q == MEASURE)) begin
        if (fall_q) begin
          hi_run_q <= 1'b0;
        end else if (edge_q && hi_run_q) begin
          hi_cnt_q <= hi_cnt_q + CNT_ONE;
        end
      end
    end
  end

  assign hi_val = hi_cnt_q;
`else
  assign hi_val = '0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= WAIT_FIRST;
      per_cnt_q <= '0;
      period_q  <= '0;
      high_q    <= '0;
      timeout_q <= 1'b0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= pend_q & i_enable;
      pend_q  <= 1'b0;
      if (!i_enable) begin
        state_q <= WAIT_FIRST;
      end else begin
        case (state_q)
          WAIT_FIRST: begin
            if (start_ev) begin
              per_cnt_q <= CNT_ONE;
              state_q   <= MEASURE;
            end
          end
          MEASURE: begin
            if (meas_ev) begin
              period_q  <= per_cnt_q;
              high_q    <= hi_val;
              timeout_q <= 1'b0;
              pend_q    <= 1'b1;
              per_cnt_q <= CNT_ONE;
            end else if (tmo_ev) begin
              period_q  <= '0;
              high_q    <= '0;
              timeout_q <= 1'b1;
              pend_q    <= 1'b1;
              state_q   <= WAIT_FIRST;
            end else begin
              per_cnt_q <= per_cnt_q + CNT_ONE;
            end
          end
          default: state_q <= WAIT_FIRST;
        endcase
      end
    end
  end

  assign o_period  = period_q;
  assign o_high    = high_q;
  assign o_valid   = valid_q;
  assign o_timeout = timeout_q;

endmodule
